// File: rtl/rv_pkg.sv
// Shared integer register-file types and sizes.
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_sb_if.sv
// Register file port bundle: N read ports, WB write port and long-op issue.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
);

    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rs_busy;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wd;
    logic                wb_long;
    logic                iss_long;
    logic [AW-1:0]       iss_rd;
    logic                issue_ready;
    logic                sb_err;

    modport master (
        output raddr, we, waddr, wd, wb_long, iss_long, iss_rd,
        input  rdata, rs_busy, issue_ready, sb_err
    );

    modport slave (
        input  raddr, we, waddr, wd, wb_long, iss_long, iss_rd,
        output rdata, rs_busy, issue_ready, sb_err
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits and outstanding long-op counter for the iterative divider.
module rf_scoreboard #(
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int MAX_LONG = 4,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] raddr,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic              wb_long,
    input  logic              iss_long,
    input  logic [AW-1:0]     iss_rd,
    output logic [NRD-1:0]    rs_busy,
    output logic              issue_ready,
    output logic              sb_err
);

    localparam int PW = $clog2(MAX_LONG + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_LONG);

    logic [NREGS-1:0] busy, busy_nxt;
    logic [PW-1:0]    pend, pend_nxt;
    logic             err_nxt;
    logic             ret, acc, set_en, dec;

    assign ret         = we & wb_long;
    assign issue_ready = (pend != PEND_MAX);
    assign acc         = iss_long & issue_ready;
    assign set_en      = acc & (iss_rd != '0);
    assign dec         = ret & (pend != '0);

    // Clear before set so a same-cycle retire and reissue leaves the register busy.
    always_comb begin
        busy_nxt = busy;
        if (ret)
            busy_nxt[waddr] = 1'b0;
        if (set_en)
            busy_nxt[iss_rd] = 1'b1;
    end

    always_comb begin
        pend_nxt = pend;
        if (acc && !dec)
            pend_nxt = pend + PW'(1);
        else if (!acc && dec)
            pend_nxt = pend - PW'(1);
    end

    always_comb begin
        err_nxt = sb_err
                | (iss_long & ~issue_ready)
                | (ret & (pend == '0))
                | (ret & (waddr != '0) & ~busy[waddr]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= '0;
            pend   <= '0;
            sb_err <= 1'b0;
        end else begin
            busy   <= busy_nxt;
            pend   <= pend_nxt;
            sb_err <= err_nxt;
        end
    end

    // A retiring write unblocks its readers immediately only when the bypass forwards its data.
    for (genvar i = 0; i < NRD; i++) begin : g_busy
        logic [AW-1:0] ra;
        logic          clr_hit;
        assign ra         = raddr[i*AW +: AW];
        assign clr_hit    = (BYPASS != 0) && ret && (waddr == ra);
        assign rs_busy[i] = busy[ra] & ~clr_hit;
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with N read ports, write-first bypass and long-op scoreboard.
module regfile_sb #(
    parameter int XLEN     = rv_pkg::XLEN,
    parameter int NREGS    = rv_pkg::NREGS,
    parameter int NRD      = 2,
    parameter int MAX_LONG = 4,
    parameter int BYPASS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    regfile_sb_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++)
                mem[r] <= '0;
        end else if (bus.we && bus.waddr != '0) begin
            mem[bus.waddr] <= bus.wd;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          byp;
        assign ra  = bus.raddr[i*AW +: AW];
        assign byp = (BYPASS != 0) && bus.we && (bus.waddr == ra) && (bus.waddr != '0);
        assign bus.rdata[i*XLEN +: XLEN] = (ra == '0) ? '0 :
                                           byp        ? bus.wd : mem[ra];
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .AW       (AW),
        .NRD      (NRD),
        .MAX_LONG (MAX_LONG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .raddr       (bus.raddr),
        .we          (bus.we),
        .waddr       (bus.waddr),
        .wb_long     (bus.wb_long),
        .iss_long    (bus.iss_long),
        .iss_rd      (bus.iss_rd),
        .rs_busy     (bus.rs_busy),
        .issue_ready (bus.issue_ready),
        .sb_err      (bus.sb_err)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reads, bypass, scoreboard hazards, throttle and errors.
module tb_regfile_sb;

    import rv_pkg::*;

    localparam int AW = REG_AW;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN), .AW(AW), .NRD(2)) bus ();

    regfile_sb #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(2), .MAX_LONG(4), .BYPASS(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    xlen_t rd0, rd1;
    assign rd0 = bus.rdata[XLEN-1:0];
    assign rd1 = bus.rdata[2*XLEN-1:XLEN];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we       = 1'b0;
        bus.waddr    = REG_ZERO;
        bus.wd       = '0;
        bus.wb_long  = 1'b0;
        bus.iss_long = 1'b0;
        bus.iss_rd   = REG_ZERO;
    endtask

    task automatic rd_addr(input reg_addr_t a0, input reg_addr_t a1);
        bus.raddr = {a1, a0};
    endtask

    task automatic wr(input reg_addr_t a, input xlen_t d, input logic lng);
        bus.we      = 1'b1;
        bus.waddr   = a;
        bus.wd      = d;
        bus.wb_long = lng;
    endtask

    task automatic issue(input reg_addr_t a);
        bus.iss_long = 1'b1;
        bus.iss_rd   = a;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd_addr(5'd0, 5'd0);
        tick();
        rst = 1'b0;

        // Reset: preload, then reset with a write and an issue in the same cycle
        wr(5'd3, 32'h55, 1'b0); tick();
        wr(5'd5, 32'h66, 1'b0); tick();
        idle(); rd_addr(5'd3, 5'd5); #1;
        check("preload_x3", rd0, 32'h55);
        rst = 1'b1;
        wr(5'd3, 32'h99, 1'b0); issue(5'd3);
        tick();
        rst = 1'b0; idle(); #1;
        check("rst_rd0", rd0, 32'h0);
        check("rst_rd1", rd1, 32'h0);
        check("rst_ready", bus.issue_ready, 1'b1);
        check("rst_err", bus.sb_err, 1'b0);
        check("rst_busy", bus.rs_busy, 2'b00);

        // Write, bypass, read
        rd_addr(5'd5, 5'd0);
        wr(5'd5, 32'hDEADBEEF, 1'b0); #1;
        check("byp_rd0", rd0, 32'hDEADBEEF);
        tick(); idle(); #1;
        check("arr_rd0_c1", rd0, 32'hDEADBEEF);
        tick(); #1;
        check("arr_rd0_c2", rd0, 32'hDEADBEEF);
        rd_addr(5'd5, 5'd6);
        wr(5'd6, 32'h11, 1'b0); #1;
        check("byp_rd1", rd1, 32'h11);
        check("nobyp_rd0", rd0, 32'hDEADBEEF);
        tick();
        rd_addr(5'd0, 5'd0);
        wr(5'd0, 32'h1234, 1'b0); #1;
        check("x0_byp", rd0, 32'h0);
        tick(); idle(); #1;
        check("x0_arr", rd0, 32'h0);

        // Long-op hazard on x7
        rd_addr(5'd0, 5'd7);
        issue(5'd7); #1;
        check("haz_issue_cyc", bus.rs_busy[1], 1'b0);
        tick(); idle();
        for (int c = 0; c < 3; c++) begin
            #1;
            check("haz_busy", bus.rs_busy[1], 1'b1);
            tick();
        end
        wr(5'd7, 32'd42, 1'b1); #1;
        check("haz_ret_busy", bus.rs_busy[1], 1'b0);
        check("haz_ret_rd1", rd1, 32'd42);
        tick(); idle(); #1;
        check("haz_after_busy", bus.rs_busy[1], 1'b0);
        check("haz_after_rd1", rd1, 32'd42);
        check("haz_err", bus.sb_err, 1'b0);

        // Throttle at four outstanding
        issue(5'd1); tick();
        issue(5'd2); tick();
        issue(5'd3); tick(); #1;
        check("thr_ready_3", bus.issue_ready, 1'b1);
        issue(5'd4); tick(); idle(); #1;
        check("thr_ready_4", bus.issue_ready, 1'b0);
        rd_addr(5'd2, 5'd4); #1;
        check("thr_busy", bus.rs_busy, 2'b11);
        wr(5'd2, 32'h22, 1'b1); #1;
        check("thr_ret_cyc", bus.issue_ready, 1'b0);
        tick(); idle(); #1;
        check("thr_ready_ret", bus.issue_ready, 1'b1);
        check("thr_err0", bus.sb_err, 1'b0);
        issue(5'd5); tick(); idle(); #1;
        check("thr_full", bus.issue_ready, 1'b0);
        check("thr_err1", bus.sb_err, 1'b0);
        rd_addr(5'd6, 5'd0);
        issue(5'd6); tick(); idle(); #1;
        check("thr_over_err", bus.sb_err, 1'b1);
        check("thr_over_ign", bus.rs_busy[0], 1'b0);
        tick(); #1;
        check("err_sticky", bus.sb_err, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0; #1;
        check("err_rst", bus.sb_err, 1'b0);

        // Same-cycle retire and reissue of x9
        rd_addr(5'd9, 5'd0);
        issue(5'd9); tick(); idle(); #1;
        check("sc_busy", bus.rs_busy[0], 1'b1);
        wr(5'd9, 32'h99, 1'b1); issue(5'd9); #1;
        check("sc_clr_cyc", bus.rs_busy[0], 1'b0);
        check("sc_byp", rd0, 32'h99);
        tick(); idle(); #1;
        check("sc_still_busy", bus.rs_busy[0], 1'b1);
        check("sc_err", bus.sb_err, 1'b0);
        issue(5'd10); tick();
        issue(5'd11); tick(); idle(); #1;
        check("sc_pend3", bus.issue_ready, 1'b1);
        issue(5'd12); tick(); idle(); #1;
        check("sc_pend4", bus.issue_ready, 1'b0);

        // Reset with ops in flight, then a stale retire
        rst = 1'b1; tick(); rst = 1'b0; #1;
        rd_addr(5'd9, 5'd10); #1;
        check("mf_ready", bus.issue_ready, 1'b1);
        check("mf_busy", bus.rs_busy, 2'b00);
        check("mf_err0", bus.sb_err, 1'b0);
        wr(5'd10, 32'd5, 1'b1); tick(); idle(); #1;
        check("mf_stale_err", bus.sb_err, 1'b1);
        check("mf_stale_rd1", rd1, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
